bcp_scheduler: RTL and testbench

//  Sequences a bank of NUM_CHK bcp_checker1 instances through the clause memory for one BCP pass.
//  - Fetches clauses and loads them into checkers (bcp_initial), then fires evaluation (en).
//  - Collects unit implications in slot order into an output FIFO.
//  - Sits between the clause store and the decision/trail logic.

---
 rtl/bcp_pkg.sv | 18 +
 rtl/bcp_impl_fifo.sv | 52 +++++
 rtl/bcp_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_bcp_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_pkg.sv
// Shared definitions for the BCP pass scheduler: FSM encoding and implication width.
package bcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EVAL,
    ST_COLLECT,
    ST_DONE
  } bcp_state_t;

  // Width of an encoded implication (variable index); never below one bit.
  function automatic int impl_width(input int var_num);
    return (var_num > 1) ? $clog2(var_num) : 1;
  endfunction

endpackage

// File: rtl/bcp_impl_fifo.sv
// Implication queue: synchronous FIFO with flush; push is accepted when full if a pop occurs the same cycle.
module bcp_impl_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & (~full | pop);
  assign pop_ok   = pop & ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bcp_scheduler.sv
// Runs one BCP pass: loads clauses into a bank of checkers, fires them, and
// gathers unit implications in slot order into the implication queue.
//
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH   | read strobe for clause ptr
//   LOAD    | broadcast clause, init pulse to current slot
//   EVAL    | en pulse to every loaded slot
//   COLLECT | scan one slot per cycle, push units, stall on full queue
//   DONE    | one-cycle done pulse
module bcp_scheduler
  import bcp_pkg::*;
#(
  parameter int VAR_NUM   = 8,
  parameter int NUM_CHK   = 4,
  parameter int CLAUSE_AW = 4,
  parameter int QDEPTH    = 4,
  localparam int IMPL_W   = impl_width(VAR_NUM)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CLAUSE_AW:0]        num_clauses,
  output logic                      mem_rd,
  output logic [CLAUSE_AW-1:0]      mem_addr,
  input  logic [VAR_NUM-1:0]        mem_type,
  input  logic [VAR_NUM-1:0]        mem_mask,
  input  logic [VAR_NUM-1:0]        mem_size,
  output logic [VAR_NUM-1:0]        chk_type,
  output logic [VAR_NUM-1:0]        chk_mask,
  output logic [VAR_NUM-1:0]        chk_size,
  output logic [NUM_CHK-1:0]        chk_init,
  output logic [NUM_CHK-1:0]        chk_en,
  input  logic [NUM_CHK-1:0]        chk_unit,
  input  logic [NUM_CHK*IMPL_W-1:0] chk_impl,
  output logic                      impl_valid,
  output logic [IMPL_W-1:0]         impl_var,
  input  logic                      impl_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int SW   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam int CW   = CLAUSE_AW + 1;
  localparam int MAXN = 1 << CLAUSE_AW;

  bcp_state_t         state, state_nxt;
  logic [CW-1:0]      n_clauses;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      ptr_inc;
  logic [CW-1:0]      num_sat;
  logic [SW-1:0]      slot;
  logic [SW-1:0]      scan;
  logic [NUM_CHK-1:0] loaded;
  logic               last_load;
  logic               last_scan;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               stall;
  logic               scan_unit;
  logic [IMPL_W-1:0]  scan_impl;

  assign num_sat    = (num_clauses > CW'(MAXN)) ? CW'(MAXN) : num_clauses;
  assign ptr_inc    = ptr + 1'b1;
  assign last_load  = (ptr_inc == n_clauses) || (slot == SW'(NUM_CHK - 1));
  assign last_scan  = (scan == SW'(NUM_CHK - 1));
  assign impl_valid = ~fifo_empty;
  assign fifo_pop   = impl_valid & impl_ready;
  assign stall      = fifo_full & ~fifo_pop;
  assign scan_unit  = loaded[scan] & chk_unit[scan];
  assign scan_impl  = chk_impl[int'(scan)*IMPL_W +: IMPL_W];
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    chk_type  = '0;
    chk_mask  = '0;
    chk_size  = '0;
    chk_init  = '0;
    chk_en    = '0;
    fifo_push = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_sat == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = ptr[CLAUSE_AW-1:0];
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        chk_type       = mem_type;
        chk_mask       = mem_mask;
        chk_size       = mem_size;
        chk_init[slot] = 1'b1;
        state_nxt      = last_load ? ST_EVAL : ST_FETCH;
      end
      ST_EVAL: begin
        chk_en    = loaded;
        state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!stall) begin
          fifo_push = scan_unit;
          if (last_scan) state_nxt = (ptr < n_clauses) ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // abort overrides whatever the current state wanted to do
    if (abort) begin
      state_nxt = ST_IDLE;
      fifo_push = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      n_clauses <= '0;
      ptr       <= '0;
      slot      <= '0;
      scan      <= '0;
      loaded    <= '0;
    end else if (abort) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      slot   <= '0;
      scan   <= '0;
      loaded <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_clauses <= num_sat;
            ptr       <= '0;
            slot      <= '0;
            scan      <= '0;
            loaded    <= '0;
          end
        end
        ST_LOAD: begin
          loaded[slot] <= 1'b1;
          ptr          <= ptr_inc;
          if (!last_load) slot <= slot + 1'b1;
        end
        ST_EVAL: scan <= '0;
        ST_COLLECT: begin
          if (!stall) begin
            if (last_scan) begin
              scan <= '0;
              if (ptr < n_clauses) begin
                loaded <= '0;
                slot   <= '0;
              end
            end else begin
              scan <= scan + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  bcp_impl_fifo #(
    .W     (IMPL_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (scan_impl),
    .pop       (fifo_pop),
    .pop_data  (impl_var),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_bcp_scheduler.sv
// Directed bench for bcp_scheduler with a registered clause memory and a
// behavioural checker bank (type bit 7 = unit, type[2:0] = implied variable).
module tb_bcp_scheduler;

  localparam int VAR_NUM   = 8;
  localparam int NUM_CHK   = 4;
  localparam int CLAUSE_AW = 4;
  localparam int QDEPTH    = 2;
  localparam int IMPL_W    = 3;

  logic                      clock;
  logic                      reset;
  logic                      start;
  logic                      abort;
  logic [CLAUSE_AW:0]        num_clauses;
  logic                      mem_rd;
  logic [CLAUSE_AW-1:0]      mem_addr;
  logic [VAR_NUM-1:0]        mem_type;
  logic [VAR_NUM-1:0]        mem_mask;
  logic [VAR_NUM-1:0]        mem_size;
  logic [VAR_NUM-1:0]        chk_type;
  logic [VAR_NUM-1:0]        chk_mask;
  logic [VAR_NUM-1:0]        chk_size;
  logic [NUM_CHK-1:0]        chk_init;
  logic [NUM_CHK-1:0]        chk_en;
  logic [NUM_CHK-1:0]        chk_unit;
  logic [NUM_CHK*IMPL_W-1:0] chk_impl;
  logic                      impl_valid;
  logic [IMPL_W-1:0]         impl_var;
  logic                      impl_ready;
  logic                      busy;
  logic                      done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mtype [16];
  logic [7:0] ck_type [NUM_CHK];

  int rd_q[$];
  int init_q[$];
  int size_q[$];
  int en_q[$];
  int pop_q[$];
  int done_cnt  = 0;
  int busy_cnt  = 0;
  int bcast_err = 0;

  bcp_scheduler #(
    .VAR_NUM   (VAR_NUM),
    .NUM_CHK   (NUM_CHK),
    .CLAUSE_AW (CLAUSE_AW),
    .QDEPTH    (QDEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_clauses (num_clauses),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_type    (mem_type),
    .mem_mask    (mem_mask),
    .mem_size    (mem_size),
    .chk_type    (chk_type),
    .chk_mask    (chk_mask),
    .chk_size    (chk_size),
    .chk_init    (chk_init),
    .chk_en      (chk_en),
    .chk_unit    (chk_unit),
    .chk_impl    (chk_impl),
    .impl_valid  (impl_valid),
    .impl_var    (impl_var),
    .impl_ready  (impl_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // clause memory: data valid the cycle after the read strobe
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_type <= '0;
      mem_mask <= '0;
      mem_size <= '0;
    end else if (mem_rd) begin
      mem_type <= mtype[mem_addr];
      mem_mask <= ~mtype[mem_addr];
      mem_size <= {4'b0, mem_addr};
    end
  end

  // checker bank model
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_unit <= '0;
      chk_impl <= '0;
      for (int k = 0; k < NUM_CHK; k++) ck_type[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CHK; k++) begin
        if (chk_init[k]) begin
          ck_type[k]  <= chk_type;
          chk_unit[k] <= 1'b0;
        end else if (chk_en[k]) begin
          chk_unit[k]                 <= ck_type[k][7];
          chk_impl[k*IMPL_W +: IMPL_W] <= ck_type[k][2:0];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (mem_rd) rd_q.push_back(int'(mem_addr));
    for (int k = 0; k < NUM_CHK; k++) if (chk_init[k]) init_q.push_back(k);
    if (chk_init != '0) begin
      size_q.push_back(int'(chk_size));
      if (chk_mask !== ~chk_type) bcast_err++;
    end
    if (chk_en != '0) en_q.push_back(int'(chk_en));
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (impl_valid && impl_ready) pop_q.push_back(int'(impl_var));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pass(input int n);
    num_clauses = (CLAUSE_AW+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    n_checks++;
    if ({busy, done, mem_rd, impl_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, mem_rd, impl_valid});
    end
    n_checks++;
    if ({mem_addr, chk_init, chk_en, impl_var, chk_type, chk_mask, chk_size} !== '0) begin
      n_fail++;
      $display("FAIL reset_vectors: got %h expected 0",
               {mem_addr, chk_init, chk_en, impl_var, chk_type, chk_mask, chk_size});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int r0 = rd_q.size();
    int i0 = init_q.size();
    int z0 = size_q.size();
    int e0 = en_q.size();
    int p0 = pop_q.size();
    int d0 = done_cnt;
    int b0 = busy_cnt;
    bit seen;
    mtype[0] = 8'h02; mtype[1] = 8'h85; mtype[2] = 8'h04;
    impl_ready = 1'b1;
    start_pass(3);
    wait_done(60, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL t1_done_timeout: got no done expected done"); end
    n_checks++;
    if (rd_q.size() - r0 != 3) begin
      n_fail++; $display("FAIL t1_rd_cnt: got %0d expected 3", rd_q.size() - r0);
    end
    n_checks++;
    if (init_q.size() - i0 != 3 || init_q[i0] != 0 || init_q[i0+1] != 1 || init_q[i0+2] != 2) begin
      n_fail++; $display("FAIL t1_init_slots: got count %0d expected slots 0,1,2", init_q.size() - i0);
    end
    n_checks++;
    if (size_q.size() - z0 != 3 || size_q[z0] != 0 || size_q[z0+1] != 1 || size_q[z0+2] != 2) begin
      n_fail++; $display("FAIL t1_bcast_size: got count %0d expected 0,1,2", size_q.size() - z0);
    end
    n_checks++;
    if (en_q.size() - e0 != 1 || en_q[e0] != 4'b0111) begin
      n_fail++; $display("FAIL t1_en: got count %0d expected one 0111", en_q.size() - e0);
    end
    n_checks++;
    if (pop_q.size() - p0 != 1 || pop_q[p0] != 5) begin
      n_fail++; $display("FAIL t1_pop: got count %0d expected one value 5", pop_q.size() - p0);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL t1_done_cnt: got %0d expected 1", done_cnt - d0);
    end
    n_checks++;
    if (busy_cnt - b0 != 12) begin
      n_fail++; $display("FAIL t1_busy_cycles: got %0d expected 12", busy_cnt - b0);
    end
    n_checks++;
    if (bcast_err != 0) begin
      n_fail++; $display("FAIL t1_bcast_mask: got %0d errors expected 0", bcast_err);
    end
  endtask

  task automatic test_two_rounds();
    int e0 = en_q.size();
    int p0 = pop_q.size();
    int r0 = rd_q.size();
    int d0 = done_cnt;
    int b0 = busy_cnt;
    bit seen;
    for (int k = 0; k < 6; k++) mtype[k] = 8'h80 | 8'(k);
    impl_ready = 1'b1;
    start_pass(6);
    wait_done(80, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL t2_done_timeout: got no done expected done"); end
    n_checks++;
    if (en_q.size() - e0 != 2 || en_q[e0] != 4'b1111 || en_q[e0+1] != 4'b0011) begin
      n_fail++; $display("FAIL t2_en: got count %0d expected 1111 then 0011", en_q.size() - e0);
    end
    n_checks++;
    if (pop_q.size() - p0 != 6) begin
      n_fail++; $display("FAIL t2_pop_cnt: got %0d expected 6", pop_q.size() - p0);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (pop_q[p0+k] != k) begin
          n_fail++; $display("FAIL t2_pop_order[%0d]: got %0d expected %0d", k, pop_q[p0+k], k);
        end
      end
    end
    n_checks++;
    if (rd_q.size() - r0 != 6 || rd_q[r0+4] != 4 || rd_q[r0+5] != 5) begin
      n_fail++; $display("FAIL t2_rd_addr: got count %0d expected addresses 0..5", rd_q.size() - r0);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL t2_done_cnt: got %0d expected 1", done_cnt - d0);
    end
    n_checks++;
    if (busy_cnt - b0 != 23) begin
      n_fail++; $display("FAIL t2_busy_cycles: got %0d expected 23", busy_cnt - b0);
    end
  endtask

  task automatic test_stall();
    int p0 = pop_q.size();
    int d0 = done_cnt;
    int exp_v [4] = '{4, 6, 1, 7};
    bit seen;
    for (int k = 0; k < 4; k++) mtype[k] = 8'h80 | 8'(exp_v[k]);
    impl_ready = 1'b0;
    start_pass(4);
    repeat (20) step();
    n_checks++;
    if ({busy, impl_valid, impl_var} !== {1'b1, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL t3_stalled: got busy=%b valid=%b var=%0d expected 1 1 4", busy, impl_valid, impl_var);
    end
    n_checks++;
    if (done_cnt - d0 != 0 || pop_q.size() - p0 != 0) begin
      n_fail++; $display("FAIL t3_no_progress: got done %0d pops %0d expected 0 0", done_cnt - d0, pop_q.size() - p0);
    end
    impl_ready = 1'b1;
    wait_done(40, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL t3_done_timeout: got no done expected done"); end
    n_checks++;
    if (pop_q.size() - p0 != 4) begin
      n_fail++; $display("FAIL t3_pop_cnt: got %0d expected 4", pop_q.size() - p0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (pop_q[p0+k] != exp_v[k]) begin
          n_fail++; $display("FAIL t3_pop_order[%0d]: got %0d expected %0d", k, pop_q[p0+k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_zero_clauses();
    int r0 = rd_q.size();
    int i0 = init_q.size();
    int e0 = en_q.size();
    int d0 = done_cnt;
    int b0 = busy_cnt;
    start_pass(0);
    n_checks++;
    if ({busy, done} !== 2'b11) begin
      n_fail++; $display("FAIL t4_first_cycle: got busy=%b done=%b expected 1 1", busy, done);
    end
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL t4_back_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    step();
    n_checks++;
    if (rd_q.size() != r0 || init_q.size() != i0 || en_q.size() != e0) begin
      n_fail++; $display("FAIL t4_no_activity: got rd %0d init %0d en %0d expected 0 0 0",
                         rd_q.size() - r0, init_q.size() - i0, en_q.size() - e0);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || busy_cnt - b0 != 1) begin
      n_fail++; $display("FAIL t4_counts: got done %0d busy %0d expected 1 1", done_cnt - d0, busy_cnt - b0);
    end
  endtask

  task automatic test_abort();
    int p0;
    int d0 = done_cnt;
    bit seen;
    for (int k = 0; k < 4; k++) mtype[k] = 8'h80 | 8'(k + 2);
    impl_ready = 1'b0;
    start_pass(4);
    repeat (20) step();
    n_checks++;
    if ({busy, impl_valid} !== 2'b11) begin
      n_fail++; $display("FAIL t5_queued: got busy=%b valid=%b expected 1 1", busy, impl_valid);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({busy, impl_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL t5_after_abort: got busy=%b valid=%b done=%b expected 0 0 0", busy, impl_valid, done);
    end
    repeat (3) step();
    n_checks++;
    if (done_cnt - d0 != 0) begin
      n_fail++; $display("FAIL t5_no_done: got %0d expected 0", done_cnt - d0);
    end
    num_clauses = 5'd1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_start_abort: got busy=%b expected 0", busy);
    end
    p0 = pop_q.size();
    mtype[0] = 8'h83;
    impl_ready = 1'b1;
    start_pass(1);
    wait_done(40, seen);
    n_checks++;
    if (!seen || pop_q.size() - p0 != 1 || pop_q[p0] != 3) begin
      n_fail++; $display("FAIL t5_rerun: got done=%b pops %0d expected done and one value 3", seen, pop_q.size() - p0);
    end
  endtask

  task automatic test_reset_midpass();
    int r0;
    int e0;
    int d0;
    bit seen;
    for (int k = 0; k < 16; k++) mtype[k] = 8'h01;
    impl_ready = 1'b1;
    start_pass(4);
    step();
    n_checks++;
    if (chk_init !== 4'b0001) begin
      n_fail++; $display("FAIL t6_mid_load: got %b expected 0001", chk_init);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, mem_rd, impl_valid, chk_init, chk_en, chk_type, mem_addr} !== '0) begin
      n_fail++; $display("FAIL t6_async_reset: got %h expected 0",
                         {busy, done, mem_rd, impl_valid, chk_init, chk_en, chk_type, mem_addr});
    end
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL t6_idle_after_reset: got busy=%b expected 0", busy);
    end
    r0 = rd_q.size();
    e0 = en_q.size();
    d0 = done_cnt;
    start_pass(2);
    step();
    num_clauses = 5'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, seen);
    n_checks++;
    if (!seen || rd_q.size() - r0 != 2 || rd_q[r0] != 0 || rd_q[r0+1] != 1) begin
      n_fail++; $display("FAIL t6_ignored_start: got done=%b reads %0d expected done and reads 0,1", seen, rd_q.size() - r0);
    end
    n_checks++;
    if (en_q.size() - e0 != 1 || en_q[e0] != 4'b0011 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL t6_en_done: got en count %0d done %0d expected 1 (0011) and 1", en_q.size() - e0, done_cnt - d0);
    end
  endtask

  task automatic test_saturate();
    int r0 = rd_q.size();
    int e0 = en_q.size();
    int d0 = done_cnt;
    bit seen;
    impl_ready = 1'b1;
    start_pass(20);
    wait_done(200, seen);
    n_checks++;
    if (!seen || rd_q.size() - r0 != 16 || rd_q[rd_q.size()-1] != 15) begin
      n_fail++; $display("FAIL sat_reads: got done=%b reads %0d expected done and 16 reads ending at 15", seen, rd_q.size() - r0);
    end
    n_checks++;
    if (en_q.size() - e0 != 4 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL sat_rounds: got en %0d done %0d expected 4 1", en_q.size() - e0, done_cnt - d0);
    end
  endtask

  initial begin
    start       = 1'b0;
    abort       = 1'b0;
    num_clauses = '0;
    impl_ready  = 1'b0;
    reset       = 1'b0;
    for (int k = 0; k < 16; k++) mtype[k] = 8'h00;
    test_reset();
    test_single();
    test_two_rounds();
    test_stall();
    test_zero_clauses();
    test_abort();
    test_reset_midpass();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
